reg_readout: RTL and testbench
==============================

// Module: reg_readout
// PURPOSE
//  Read side of the R0/R1 register file. Decodes the OUT opcodes (100, 101) and DUMP (110).
//  Snapshots the R0_out/R1_out debug values into a small first-word-fall-through FIFO.
//  Presents the bytes on a valid/ready stream towards the FSM/UART transmitter.
//  Sits between REG and the UART TX path; the register-file writer itself is untouched.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >= 2
//  CNT_W  8  width of the saturating drop counter
// PORTS
//  clock      in   1             single system clock, rising edge
//  reset_n    in   1             asynchronous, active-low reset
//  ena        in   1             command qualifier, same as the REG enable
//  opcode     in   3             instruction opcode shared with REG
//  r0_in      in   8             current R0 value (REG R0_out)
//  r1_in      in   8             current R1 value (REG R1_out)
//  out_data   out  8             byte at FIFO head
//  out_valid  out  1             FIFO non-empty
//  out_ready  in   1             downstream accepts out_data this cycle
//  busy       out  1             DUMP second beat pending
//  level      out  clog2(DEPTH)+1  FIFO occupancy
//  drop_cnt   out  CNT_W         rejected pushes, saturating
//  drop_clr   in   1             synchronous clear of drop_cnt
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (reset_n=0, any time, including mid-DUMP or mid-transfer):
//   - state=IDLE, FIFO empty.
//   - out_valid=0, out_data=0, busy=0, level=0, drop_cnt=0.
//  Commands are sampled at posedge when ena=1 and state=IDLE:
//   - 100: push r0_in.
//   - 101: push r1_in.
//   - 110: push r0_in, latch r1_in into a hold register, go to DUMP2.
//   - other opcodes: no action.
//   - ena=0: no command action; the output side keeps draining.
//  FSM:
//   - IDLE -> DUMP2 on an accepted 110.
//   - DUMP2 -> IDLE unconditionally after one cycle; that cycle pushes the held R1.
//   - busy=1 only in DUMP2. The held value makes the DUMP pair a same-cycle snapshot.
//   - A qualifying command (ena=1, opcode 100/101/110) arriving in DUMP2 is discarded and counts as a drop.
//  FIFO:
//   - First-word fall-through: out_data = head entry; out_valid = (level != 0).
//   - out_data holds its last value when empty.
//   - Pop occurs when out_valid & out_ready at the clock edge.
//   - Latency: command at edge N gives out_valid=1 after edge N; 110 adds its second byte after edge N+1.
//   - Push is accepted if level < DEPTH, or if a pop occurs in the same cycle (full + push + pop: level stays DEPTH).
//   - Simultaneous push and pop when level==1 keeps out_valid high with the new byte next cycle.
//   - Pointers wrap modulo DEPTH.
//  Overflow:
//   - A rejected push leaves the FIFO unchanged; drop_cnt += 1, saturating at 2^CNT_W-1.
//   - A DUMP whose first beat is rejected still attempts the R1 beat.
//   - drop_clr zeroes drop_cnt; drop_clr and a drop in the same cycle give drop_cnt=1.
//  out_ready may be asserted with out_valid=0; it has no effect.
// TESTING
//  1. Reset: R0=0x5A, op=100, ena=1 -> out_valid=1, out_data=0x5A, level=1; out_ready=1 one cycle -> level=0, out_valid=0.
//  2. DUMP: R0=0x11, R1=0x22, op=110; R1 changes to 0x99 next cycle -> stream delivers 0x11 then 0x22; busy high exactly 1 cycle.
//  3. Overflow: out_ready=0, 6 consecutive op=101 with R1=1..6 (DEPTH=4) -> level=4, drop_cnt=2; drain order 1,2,3,4.
//  4. Full + push + pop: level=4, op=100 with out_ready=1 -> level stays 4; new byte arrives last in drain order.
//  5. Command during DUMP2: op=110 then op=101 the next cycle -> only 2 bytes queued, drop_cnt=1.
//  6. Async reset: reset_n low mid-DUMP with level=3 -> all outputs 0 immediately; op=100 after release -> normal single push.

Source files
------------

// File: rtl/reg_readout.sv
// Read side of the R0/R1 register file: OUT/DUMP opcodes snapshot R0/R1 into a FWFT byte FIFO.
// Latency: a byte is visible on out_data one cycle after its command; DUMP's R1 byte one cycle later.
// Backpressure: out_valid/out_ready stream; pushes into a full FIFO without a same-cycle pop are dropped and counted.
module reg_readout #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ena,
    input  logic [2:0]               opcode,
    input  logic [7:0]               r0_in,
    input  logic [7:0]               r1_in,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     drop_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] L_DEPTH = LVL_W'(DEPTH);
    localparam logic [CNT_W:0]   L_CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    typedef enum logic {S_IDLE, S_DUMP2} state_t;

    state_t             r_state;
    logic               r_busy;
    logic [7:0]         r_hold;
    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [7:0]         r_last;
    logic [CNT_W-1:0]   r_drop;

    logic               w_cmd_q;
    logic               w_pop;
    logic               w_push_req;
    logic [7:0]         w_push_dat;
    logic               w_cmd_drop;
    logic               w_start_dump;
    logic               w_push_ok;
    logic               w_push_rej;
    logic [1:0]         w_drop_n;
    logic [CNT_W-1:0]   w_drop_base;
    logic [CNT_W:0]     w_drop_sum;

    // Command decode and push arbitration; DUMP2 owns the push slot for the held R1 byte
    always_comb begin
        w_cmd_q      = ena && (opcode == 3'b100 || opcode == 3'b101 || opcode == 3'b110);
        w_pop        = (r_level != '0) && out_ready;
        w_push_req   = 1'b0;
        w_push_dat   = r0_in;
        w_cmd_drop   = 1'b0;
        w_start_dump = 1'b0;
        if (r_state == S_DUMP2) begin
            w_push_req = 1'b1;
            w_push_dat = r_hold;
            w_cmd_drop = w_cmd_q;
        end else if (w_cmd_q) begin
            w_push_req   = 1'b1;
            w_push_dat   = (opcode == 3'b101) ? r1_in : r0_in;
            w_start_dump = (opcode == 3'b110);
        end
        w_push_ok   = w_push_req && ((r_level < L_DEPTH) || w_pop);
        w_push_rej  = w_push_req && !w_push_ok;
        w_drop_n    = {1'b0, w_cmd_drop} + {1'b0, w_push_rej};
        w_drop_base = drop_clr ? '0 : r_drop;
        w_drop_sum  = (CNT_W+1)'(w_drop_base) + (CNT_W+1)'(w_drop_n);
    end

    // DUMP sequencer: latch R1 on the first beat so both bytes come from the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_hold  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_dump) begin
                        r_state <= S_DUMP2;
                        r_busy  <= 1'b1;
                        r_hold  <= r1_in;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage and pointers; r_last keeps out_data stable once the FIFO runs dry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_last   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_push_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
        end
    end

    // Saturating drop counter; a clear and a drop together leave only the new drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= '0;
        end else if (w_drop_sum > L_CNT_MAX) begin
            r_drop <= {CNT_W{1'b1}};
        end else begin
            r_drop <= w_drop_sum[CNT_W-1:0];
        end
    end

    assign out_valid = (r_level != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : r_last;
    assign busy      = r_busy;
    assign level     = r_level;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_reg_readout.sv
// Bench for reg_readout: directed scenarios with literal expectations plus random traffic.
// Outputs are compared against a queue-based model at every falling edge.
// Inputs change only after the falling-edge compare, so the rising edge always sees stable values.
module tb_reg_readout;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         ena = 1'b0;
    logic [2:0]   opcode = 3'b000;
    logic [7:0]   r0_in = 8'h00;
    logic [7:0]   r1_in = 8'h00;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic [2:0]   level;
    logic [7:0]   drop_cnt;
    logic         drop_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    // model state
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    logic [7:0] m_hold;
    bit         m_pend;
    int         m_drops;

    reg_readout #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .ena(ena), .opcode(opcode),
        .r0_in(r0_in), .r1_in(r1_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .level(level), .drop_cnt(drop_cnt),
        .drop_clr(drop_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = 8'h00;
        m_hold  = 8'h00;
        m_pend  = 0;
        m_drops = 0;
    endtask

    // Next state from the current model and the inputs about to be sampled
    task automatic model_step();
        bit         pop;
        bit         have;
        logic [7:0] cand;
        int         nd;
        bit         qual;
        pop  = (m_q.size() != 0) && out_ready;
        have = 0;
        cand = 8'h00;
        nd   = 0;
        qual = ena && (opcode == 3'd4 || opcode == 3'd5 || opcode == 3'd6);
        if (m_pend) begin
            have   = 1;
            cand   = m_hold;
            m_pend = 0;
            if (qual) nd++;
        end else if (qual) begin
            have = 1;
            cand = (opcode == 3'd5) ? r1_in : r0_in;
            if (opcode == 3'd6) begin
                m_pend = 1;
                m_hold = r1_in;
            end
        end
        if (have && !(m_q.size() < DEPTH || pop)) begin
            nd++;
            have = 0;
        end
        if (pop) m_last = m_q.pop_front();
        if (have) m_q.push_back(cand);
        m_drops = (drop_clr ? 0 : m_drops) + nd;
        if (m_drops > CMAX) m_drops = CMAX;
    endtask

    task automatic compare_all();
        chk("out_valid", int'(out_valid), (m_q.size() != 0) ? 1 : 0);
        chk("level", int'(level), m_q.size());
        chk("busy", int'(busy), m_pend ? 1 : 0);
        chk("drop_cnt", int'(drop_cnt), m_drops);
        chk("out_data", int'(out_data), int'((m_q.size() != 0) ? m_q[0] : m_last));
    endtask

    // One clock: drive inputs, advance the model, then compare at the following falling edge
    task automatic cycle(input logic e, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic rdy, input logic clr);
        ena = e; opcode = op; r0_in = a; r1_in = b; out_ready = rdy; drop_clr = clr;
        model_step();
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        #23;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data", int'(out_data), 0);
        chk("reset_level", int'(level), 0);
        @(negedge clock);
        reset_n = 1'b1;
        compare_all();

        // 1: single OUT R0 and drain
        cycle(1'b1, 3'd4, 8'h5A, 8'h00, 1'b0, 1'b0);
        chk("t1_data", int'(out_data), 8'h5A);
        chk("t1_level", int'(level), 1);
        idle(1'b1);
        chk("t1_empty", int'(out_valid), 0);
        chk("t1_hold", int'(out_data), 8'h5A);

        // 2: DUMP snapshot, R1 changes on the second beat
        cycle(1'b1, 3'd6, 8'h11, 8'h22, 1'b0, 1'b0);
        chk("t2_busy1", int'(busy), 1);
        chk("t2_head", int'(out_data), 8'h11);
        cycle(1'b0, 3'd0, 8'h11, 8'h99, 1'b0, 1'b0);
        chk("t2_busy0", int'(busy), 0);
        chk("t2_level", int'(level), 2);
        idle(1'b1);
        chk("t2_second", int'(out_data), 8'h22);
        idle(1'b1);

        // 3: overflow with 6 pushes into depth 4
        for (int i = 1; i <= 6; i++) cycle(1'b1, 3'd5, 8'h00, 8'(i), 1'b0, 1'b0);
        chk("t3_level", int'(level), 4);
        chk("t3_drops", int'(drop_cnt), 2);
        chk("t3_head", int'(out_data), 1);

        // 4: full + push + pop keeps level at DEPTH, new byte last
        cycle(1'b1, 3'd4, 8'h77, 8'h00, 1'b1, 1'b0);
        chk("t4_level", int'(level), 4);
        chk("t4_drops", int'(drop_cnt), 2);
        begin
            logic [7:0] exp_order [4];
            exp_order = '{8'h02, 8'h03, 8'h04, 8'h77};
            for (int i = 0; i < 4; i++) begin
                chk("t4_order", int'(out_data), int'(exp_order[i]));
                idle(1'b1);
            end
        end
        chk("t4_empty", int'(out_valid), 0);

        // drop counter saturation
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'd5, 8'h00, 8'(i), 1'b0, 1'b0);
        chk("sat_drops", int'(drop_cnt), CMAX);
        for (int i = 0; i < 4; i++) idle(1'b1);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("clr_drops", int'(drop_cnt), 0);

        // 5: command during DUMP2 is dropped
        cycle(1'b1, 3'd6, 8'hA1, 8'hA2, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 8'h00, 8'hB0, 1'b0, 1'b0);
        chk("t5_level", int'(level), 2);
        chk("t5_drops", int'(drop_cnt), 1);
        idle(1'b1);
        chk("t5_second", int'(out_data), 8'hA2);
        idle(1'b1);

        // 6: async reset mid-DUMP with level 3
        cycle(1'b1, 3'd4, 8'h31, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 8'h00, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 8'h33, 8'h34, 1'b0, 1'b0);
        chk("t6_pre_level", int'(level), 3);
        chk("t6_pre_busy", int'(busy), 1);
        ena = 1'b0; opcode = 3'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_data", int'(out_data), 0);
        chk("t6_rst_level", int'(level), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_drops", int'(drop_cnt), 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1'b1, 3'd4, 8'h3C, 8'h00, 1'b0, 1'b0);
        chk("t6_level", int'(level), 1);
        chk("t6_data", int'(out_data), 8'h3C);
        chk("t6_busy", int'(busy), 0);
        idle(1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       e;
            logic [2:0] op;
            e  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(4, 6)) : 3'($urandom_range(0, 7));
            cycle(e, op, 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
